dmem_bus_arbiter: RTL and testbench

//  Owns the single data-memory port. Arbitrates between the core LSU (driven by decode's en_mem_re/en_mem_wr, func3)
//  and a DMA/debug requester. Sequences one multi-cycle access at a time: byte-lane packing, ack wait, timeout, load extension.

---
 rtl/dmem_bus_arbiter_pkg.sv | 20 ++
 rtl/dmem_lane_fmt.sv | 46 ++++
 rtl/dmem_bus_arbiter.sv | 172 +++++++++++++++++
 tb/tb_dmem_bus_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_bus_arbiter_pkg.sv
// Shared constants for the data-memory arbiter: load/store size codes and FSM encodings.
package dmem_bus_arbiter_pkg;

   localparam logic [2:0] LS_B  = 3'b000;
   localparam logic [2:0] LS_H  = 3'b001;
   localparam logic [2:0] LS_W  = 3'b010;
   localparam logic [2:0] LS_BU = 3'b100;
   localparam logic [2:0] LS_HU = 3'b101;

   typedef logic [2:0] arb_state_t;

   localparam arb_state_t ARB_IDLE = 3'd0;
   localparam arb_state_t ARB_CORE = 3'd1;
   localparam arb_state_t ARB_DMA  = 3'd2;
   localparam arb_state_t ARB_DONE = 3'd3;
   localparam arb_state_t ARB_CERR = 3'd4;

   localparam int unsigned TIMEOUT_DEF = 15;

endpackage

// File: rtl/dmem_lane_fmt.sv
// Byte-lane formatter: store lane enables/replication, load lane extraction and extension,
// and alignment check for a single core access.
module dmem_lane_fmt
   import dmem_bus_arbiter_pkg::*;
(
   input  logic [2:0]  func3,
   input  logic [1:0]  lane,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] mem_wdata,
   output logic [31:0] ext_rdata,
   output logic        misaligned
);

   logic [31:0] byte_sh;
   logic [31:0] half_sh;

   assign byte_sh = rdata >> {lane, 3'b000};
   assign half_sh = rdata >> {lane[1], 4'b0000};

   // func3[2] selects zero extension for the unsigned load variants.
   always_comb begin
      be         = 4'b1111;
      mem_wdata  = wdata;
      ext_rdata  = rdata;
      misaligned = 1'b0;
      case (func3)
         LS_B, LS_BU: begin
            be         = 4'b0001 << lane;
            mem_wdata  = {4{wdata[7:0]}};
            ext_rdata  = func3[2] ? {24'b0, byte_sh[7:0]} : {{24{byte_sh[7]}}, byte_sh[7:0]};
         end
         LS_H, LS_HU: begin
            be         = 4'b0011 << lane;
            mem_wdata  = {2{wdata[15:0]}};
            ext_rdata  = func3[2] ? {16'b0, half_sh[15:0]} : {{16{half_sh[15]}}, half_sh[15:0]};
            misaligned = lane[0];
         end
         default: begin
            misaligned = |lane;
         end
      endcase
   end

endmodule

// File: rtl/dmem_bus_arbiter.sv
// Data-memory port owner: round-robin arbitration between core LSU and DMA, one registered
// access at a time with ack wait, timeout and load extension.
module dmem_bus_arbiter
   import dmem_bus_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              core_rd,
   input  logic              core_wr,
   input  logic [2:0]        core_func3,
   input  logic [ADDR_W-1:0] core_addr,
   input  logic [31:0]       core_wdata,
   output logic              core_stall,
   output logic              core_done,
   output logic [31:0]       core_rdata,
   output logic              core_err,
   input  logic              dma_req,
   input  logic              dma_we,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [31:0]       dma_wdata,
   output logic              dma_done,
   output logic [31:0]       dma_rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        mem_be,
   output logic [31:0]       mem_wdata,
   input  logic              mem_ack,
   input  logic [31:0]       mem_rdata
);

   localparam logic [3:0] TMO_LAST = 4'(TIMEOUT - 1);

   arb_state_t        state_q, state_d;
   logic              last_core_q;
   logic              owner_core_q;
   logic [3:0]        timer_q;
   logic [2:0]        func3_q;
   logic [1:0]        lane_q;
   logic              mem_req_q, mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [3:0]        mem_be_q;
   logic [31:0]       mem_wdata_q, core_rdata_q, dma_rdata_q;

   logic        core_any, grant_core, grant_dma, tmo;
   logic [2:0]  fmt_func3;
   logic [1:0]  fmt_lane;
   logic [3:0]  fmt_be;
   logic [31:0] fmt_wdata, fmt_rdata;
   logic        fmt_mis;
   logic        unused_dma_lane;

   assign unused_dma_lane = ^dma_addr[1:0];

   assign core_any   = core_rd | core_wr;
   // Tie goes to whoever did not win last; a lone requester wins immediately.
   assign grant_core = core_any & (~dma_req | ~last_core_q);
   assign grant_dma  = dma_req & ~grant_core;
   assign tmo        = ~mem_ack & (timer_q == TMO_LAST);

   // Request formatting uses live core inputs in IDLE; extraction uses the latched access.
   assign fmt_func3 = (state_q == ARB_IDLE) ? core_func3 : func3_q;
   assign fmt_lane  = (state_q == ARB_IDLE) ? core_addr[1:0] : lane_q;

   dmem_lane_fmt u_lane_fmt (
      .func3      (fmt_func3),
      .lane       (fmt_lane),
      .wdata      (core_wdata),
      .rdata      (mem_rdata),
      .be         (fmt_be),
      .mem_wdata  (fmt_wdata),
      .ext_rdata  (fmt_rdata),
      .misaligned (fmt_mis)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         ARB_IDLE: begin
            if (grant_core) begin
               state_d = fmt_mis ? ARB_CERR : ARB_CORE;
            end else if (grant_dma) begin
               state_d = ARB_DMA;
            end
         end
         ARB_CORE: begin
            if (mem_ack)  state_d = ARB_DONE;
            else if (tmo) state_d = ARB_CERR;
         end
         ARB_DMA: begin
            // A timed-out DMA access is retried through normal arbitration.
            if (mem_ack)  state_d = ARB_DONE;
            else if (tmo) state_d = ARB_IDLE;
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ARB_IDLE;
         last_core_q  <= 1'b0;
         owner_core_q <= 1'b0;
         timer_q      <= '0;
         func3_q      <= '0;
         lane_q       <= '0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_be_q     <= '0;
         mem_wdata_q  <= '0;
         core_rdata_q <= '0;
         dma_rdata_q  <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            ARB_IDLE: begin
               timer_q <= '0;
               if (grant_core) begin
                  last_core_q  <= 1'b1;
                  owner_core_q <= 1'b1;
                  func3_q      <= core_func3;
                  lane_q       <= core_addr[1:0];
                  if (!fmt_mis) begin
                     mem_req_q   <= 1'b1;
                     mem_we_q    <= core_wr;
                     mem_addr_q  <= {core_addr[ADDR_W-1:2], 2'b00};
                     mem_be_q    <= core_wr ? fmt_be : 4'b1111;
                     mem_wdata_q <= fmt_wdata;
                  end
               end else if (grant_dma) begin
                  last_core_q  <= 1'b0;
                  owner_core_q <= 1'b0;
                  mem_req_q    <= 1'b1;
                  mem_we_q     <= dma_we;
                  mem_addr_q   <= {dma_addr[ADDR_W-1:2], 2'b00};
                  mem_be_q     <= 4'b1111;
                  mem_wdata_q  <= dma_wdata;
               end
            end
            ARB_CORE, ARB_DMA: begin
               if (mem_ack) begin
                  mem_req_q <= 1'b0;
                  if (owner_core_q) core_rdata_q <= fmt_rdata;
                  else              dma_rdata_q  <= mem_rdata;
               end else if (tmo) begin
                  mem_req_q <= 1'b0;
               end else begin
                  timer_q <= timer_q + 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign core_done  = (state_q == ARB_DONE) & owner_core_q;
   assign dma_done   = (state_q == ARB_DONE) & ~owner_core_q;
   assign core_err   = (state_q == ARB_CERR);
   assign core_stall = core_any & ~core_done & ~core_err;
   assign core_rdata = core_rdata_q;
   assign dma_rdata  = dma_rdata_q;
   assign mem_req    = mem_req_q;
   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_be     = mem_be_q;
   assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_dmem_bus_arbiter.sv
// Scoreboard bench for dmem_bus_arbiter: expected memory requests and completions are queued
// at stimulus time and checked when the DUT produces them.
module tb_dmem_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        core_rd = 0, core_wr = 0;
   logic [2:0]  core_func3 = 0;
   logic [31:0] core_addr = 0, core_wdata = 0;
   logic        core_stall, core_done, core_err;
   logic [31:0] core_rdata;
   logic        dma_req = 0, dma_we = 0;
   logic [31:0] dma_addr = 0, dma_wdata = 0;
   logic        dma_done;
   logic [31:0] dma_rdata;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   always #5 clk = ~clk;

   dmem_bus_arbiter #(.ADDR_W(32), .TIMEOUT(15)) dut (
      .clk(clk), .rst_n(rst_n),
      .core_rd(core_rd), .core_wr(core_wr), .core_func3(core_func3), .core_addr(core_addr),
      .core_wdata(core_wdata), .core_stall(core_stall), .core_done(core_done),
      .core_rdata(core_rdata), .core_err(core_err),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_done(dma_done), .dma_rdata(dma_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   int n_chk = 0;
   int n_bad = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } mem_exp_t;

   typedef struct {
      logic        err;
      logic        chk_data;
      logic [31:0] rdata;
   } done_exp_t;

   mem_exp_t  mem_q[$];
   done_exp_t core_q[$];
   done_exp_t dma_q[$];

   int          ack_dly = 1;
   int          skip_reqs = 0;
   logic [31:0] resp_data = 0;

   // Memory responder: acks after ack_dly cycles, or never for the next skip_reqs requests.
   initial begin
      int   cnt;
      bit   ign;
      logic prev;
      cnt = 0; ign = 0; prev = 0;
      mem_ack = 0; mem_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         if (!rst_n) begin
            mem_ack = 0; prev = 0; ign = 0;
         end else begin
            if (mem_req && !prev) begin
               ign = (skip_reqs > 0);
               if (ign) skip_reqs--;
               cnt = 0;
            end
            prev = mem_req;
            if (mem_req && !ign) begin
               cnt++;
               if (cnt >= ack_dly) begin
                  mem_ack = 1; mem_rdata = resp_data;
               end
            end else begin
               mem_ack = 0;
            end
         end
      end
   end

   logic req_prev = 0, ack_prev = 0;
   int   req_len = 0, last_len = 0;

   always @(negedge clk) begin
      mem_exp_t  m;
      done_exp_t d;
      if (!rst_n) begin
         req_prev = 0; ack_prev = 0;
      end else begin
         if (mem_req && !req_prev) begin
            if (mem_q.size() == 0) begin
               check_eq("mem_unexpected", 1, 0);
            end else begin
               m = mem_q.pop_front();
               check_eq("mem_we", mem_we, m.we);
               check_eq("mem_addr", mem_addr, m.addr);
               check_eq("mem_be", mem_be, m.be);
               check_eq("mem_wdata", mem_wdata, m.wdata);
            end
            req_len = 0;
         end
         if (mem_req) req_len++;
         if (!mem_req && req_prev) last_len = req_len;
         if (core_done || core_err) begin
            if (core_q.size() == 0) begin
               check_eq("core_unexpected", 1, 0);
            end else begin
               d = core_q.pop_front();
               check_eq("core_err", core_err, d.err);
               check_eq("core_ack_latency", ack_prev, !d.err);
               if (d.chk_data) check_eq("core_rdata", core_rdata, d.rdata);
            end
         end
         if (dma_done) begin
            if (dma_q.size() == 0) begin
               check_eq("dma_unexpected", 1, 0);
            end else begin
               d = dma_q.pop_front();
               check_eq("dma_ack_latency", ack_prev, 1);
               if (d.chk_data) check_eq("dma_rdata", dma_rdata, d.rdata);
            end
         end
         req_prev = mem_req;
         ack_prev = mem_ack;
      end
   end

   task automatic core_op(input string tag, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rresp, input int dly, input bit exp_mem,
                          input logic [3:0] ebe, input logic [31:0] ewd, input logic eerr,
                          input logic [31:0] erd);
      mem_exp_t  m;
      done_exp_t d;
      int        t;
      if (exp_mem) begin
         m.we = wr; m.addr = {addr[31:2], 2'b00}; m.be = ebe; m.wdata = ewd;
         mem_q.push_back(m);
      end
      d.err = eerr; d.chk_data = !wr && !eerr; d.rdata = erd;
      core_q.push_back(d);
      resp_data = rresp;
      ack_dly = dly;
      @(negedge clk);
      core_rd = !wr; core_wr = wr; core_func3 = f3; core_addr = addr; core_wdata = wdata;
      #1;
      check_eq({tag, "_stall_hi"}, core_stall, 1);
      t = 0;
      while (!(core_done || core_err) && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) check_eq({tag, "_hang"}, 0, 1);
      check_eq({tag, "_stall_lo"}, core_stall, 0);
      if (!exp_mem) check_eq({tag, "_no_req"}, mem_req, 0);
      core_rd = 0; core_wr = 0;
   endtask

   task automatic dma_read(input string tag, input logic [31:0] addr, input logic [31:0] rresp,
                           input int dly, input int retries);
      mem_exp_t  m;
      done_exp_t d;
      int        t;
      m.we = 0; m.addr = {addr[31:2], 2'b00}; m.be = 4'hF; m.wdata = 32'h5A5A_0000;
      for (int i = 0; i <= retries; i++) mem_q.push_back(m);
      d.err = 0; d.chk_data = 1; d.rdata = rresp;
      dma_q.push_back(d);
      resp_data = rresp;
      ack_dly = dly;
      skip_reqs = retries;
      @(negedge clk);
      dma_req = 1; dma_we = 0; dma_addr = addr; dma_wdata = 32'h5A5A_0000;
      t = 0;
      while (!dma_done && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (t >= 300) check_eq({tag, "_hang"}, 0, 1);
      check_eq({tag, "_no_err"}, core_err, 0);
      dma_req = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      mem_exp_t  m;
      done_exp_t d;
      int        t, nc, nd;

      #3;
      check_eq("rst_mem_req", mem_req, 0);
      check_eq("rst_done_err", {core_done, core_err, dma_done}, 0);
      check_eq("rst_mem_be", mem_be, 0);
      check_eq("rst_rdata", core_rdata, 0);
      repeat (3) @(negedge clk);
      rst_n = 1;

      // Stores: lane enables and replication.
      core_op("sw", 1, 3'b010, 32'h100, 32'hDEAD_BEEF, 0, 2, 1, 4'hF, 32'hDEAD_BEEF, 0, 0);
      core_op("sb", 1, 3'b000, 32'h102, 32'h0000_00A5, 0, 1, 1, 4'b0100, 32'hA5A5_A5A5, 0, 0);
      core_op("sh", 1, 3'b001, 32'h102, 32'h0000_1234, 0, 3, 1, 4'b1100, 32'h1234_1234, 0, 0);

      // Loads: lane extraction and extension.
      core_op("lb", 0, 3'b000, 32'h103, 0, 32'h80FF_0000, 2, 1, 4'hF, 0, 0, 32'hFFFF_FF80);
      core_op("lbu", 0, 3'b100, 32'h103, 0, 32'h80FF_0000, 1, 1, 4'hF, 0, 0, 32'h0000_0080);
      core_op("lh", 0, 3'b001, 32'h102, 0, 32'h80FF_0000, 2, 1, 4'hF, 0, 0, 32'hFFFF_80FF);
      core_op("lhu", 0, 3'b101, 32'h100, 0, 32'h1234_8765, 1, 1, 4'hF, 0, 0, 32'h0000_8765);
      core_op("lw", 0, 3'b010, 32'h104, 0, 32'hCAFE_F00D, 1, 1, 4'hF, 0, 0, 32'hCAFE_F00D);
      core_op("lb1", 0, 3'b000, 32'h101, 0, 32'h0000_7F00, 1, 1, 4'hF, 0, 0, 32'h0000_007F);

      // Misaligned accesses never reach memory.
      core_op("sh_mis", 1, 3'b001, 32'h101, 32'h1111, 0, 1, 0, 0, 0, 1, 0);
      core_op("lw_mis", 0, 3'b010, 32'h102, 0, 0, 1, 0, 0, 0, 1, 0);

      // Core timeout: request held exactly 15 cycles, then error.
      skip_reqs = 1;
      core_op("lw_tmo", 0, 3'b010, 32'h180, 0, 0, 1, 1, 4'hF, 0, 1, 0);
      @(negedge clk);
      check_eq("tmo_len", last_len, 15);

      dma_read("dma_rd", 32'h203, 32'h0BAD_F00D, 2, 0);
      dma_read("dma_retry", 32'h208, 32'h1357_9BDF, 3, 1);

      // Both held: grants must alternate core, DMA, core, DMA.
      resp_data = 32'h2468_ACE0;
      ack_dly = 1;
      for (int i = 0; i < 2; i++) begin
         m.we = 1; m.addr = 32'h300; m.be = 4'hF; m.wdata = 32'h0102_0304; mem_q.push_back(m);
         m.we = 0; m.addr = 32'h400; m.be = 4'hF; m.wdata = 32'h0; mem_q.push_back(m);
         d.err = 0; d.chk_data = 0; d.rdata = 0; core_q.push_back(d);
         d.chk_data = 1; d.rdata = 32'h2468_ACE0; dma_q.push_back(d);
      end
      @(negedge clk);
      core_wr = 1; core_func3 = 3'b010; core_addr = 32'h300; core_wdata = 32'h0102_0304;
      dma_req = 1; dma_we = 0; dma_addr = 32'h400; dma_wdata = 0;
      t = 0; nd = 0;
      while (nd < 2 && t < 300) begin
         @(negedge clk);
         t++;
         if (dma_done) nd++;
      end
      if (t >= 300) check_eq("rr_hang", 0, 1);
      core_wr = 0; dma_req = 0;

      // Reset during an access, then the core must win the first tie.
      skip_reqs = 1;
      m.we = 0; m.addr = 32'h500; m.be = 4'hF; m.wdata = 0; mem_q.push_back(m);
      @(negedge clk);
      core_rd = 1; core_func3 = 3'b010; core_addr = 32'h500; core_wdata = 0;
      repeat (3) @(negedge clk);
      check_eq("pre_rst_req", mem_req, 1);
      #2 rst_n = 0;
      #1;
      check_eq("arst_mem_req", mem_req, 0);
      check_eq("arst_done_err", {core_done, core_err, dma_done}, 0);
      check_eq("arst_mem_be", mem_be, 0);
      core_rd = 0;
      core_q.delete();
      skip_reqs = 0;
      @(negedge clk);
      rst_n = 1;
      resp_data = 32'h7777_0001;
      ack_dly = 2;
      m.we = 0; m.addr = 32'h600; m.be = 4'hF; m.wdata = 0; mem_q.push_back(m);
      m.we = 0; m.addr = 32'h700; m.be = 4'hF; m.wdata = 0; mem_q.push_back(m);
      d.err = 0; d.chk_data = 1; d.rdata = 32'h7777_0001;
      core_q.push_back(d);
      dma_q.push_back(d);
      @(negedge clk);
      core_rd = 1; core_func3 = 3'b010; core_addr = 32'h600;
      dma_req = 1; dma_we = 0; dma_addr = 32'h700;
      t = 0; nc = 0; nd = 0;
      while ((nc == 0 || nd == 0) && t < 300) begin
         @(negedge clk);
         t++;
         if (core_done) begin nc++; core_rd = 0; end
         if (dma_done) begin nd++; dma_req = 0; end
      end
      if (t >= 300) check_eq("post_rst_hang", 0, 1);
      core_rd = 0; dma_req = 0;
      repeat (4) @(negedge clk);

      check_eq("mem_q_left", mem_q.size(), 0);
      check_eq("core_q_left", core_q.size(), 0);
      check_eq("dma_q_left", dma_q.size(), 0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
